// File: rtl/morse_key_classifier.sv
// Morse key front end: synchronises and debounces the raw key, times presses
// and releases in millisecond ticks, and emits dot/dash/space plus gap markers.
module morse_key_classifier #(
    parameter int TICK_DIV      = 27000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int DASH_MS       = 200,
    parameter int LETTER_GAP_MS = 600,
    parameter int WORD_GAP_MS   = 1400
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       key_in,
    output logic       key_db,
    output logic [1:0] tap,
    output logic       tap_valid,
    output logic       letter_end,
    output logic       word_end
);

    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [11:0]   DEB_TH    = 12'(DEBOUNCE_MS);
    localparam logic [11:0]   DASH_TH   = 12'(DASH_MS);
    localparam logic [11:0]   LET_TH    = 12'(LETTER_GAP_MS);
    localparam logic [11:0]   WORD_TH   = 12'(WORD_GAP_MS);
    localparam logic [11:0]   CNT_MAX   = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    logic          sync_q, key_s_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_s;
    logic [11:0]   db_cnt_q, db_cnt_d;
    logic          key_db_q, key_db_d, key_db_prev_q;
    logic          rise_s, fall_s;
    state_t        state_q;
    logic [11:0]   press_cnt_q, gap_cnt_q;
    logic [11:0]   press_inc_s, gap_inc_s;
    logic          letter_done_q;
    logic [1:0]    tap_q;
    logic          tap_valid_q, letter_end_q, word_end_q;

    assign tick_s      = (tick_cnt_q == TICK_LAST);
    assign rise_s      = key_db_q & ~key_db_prev_q;
    assign fall_s      = ~key_db_q & key_db_prev_q;
    assign press_inc_s = (press_cnt_q == CNT_MAX) ? press_cnt_q : press_cnt_q + 12'd1;
    assign gap_inc_s   = (gap_cnt_q == CNT_MAX) ? gap_cnt_q : gap_cnt_q + 12'd1;

    // Free-running tick divider and debounce next-state
    always_comb begin
        tick_cnt_d = tick_s ? '0 : tick_cnt_q + TW'(1);
        db_cnt_d   = db_cnt_q;
        key_db_d   = key_db_q;
        if (key_s_q == key_db_q) begin
            db_cnt_d = 12'd0;
        end else if (tick_s) begin
            if (db_cnt_q + 12'd1 >= DEB_TH) begin
                key_db_d = ~key_db_q;
                db_cnt_d = 12'd0;
            end else begin
                db_cnt_d = db_cnt_q + 12'd1;
            end
        end else begin
            db_cnt_d = db_cnt_q;
        end
    end

    // Synchroniser, tick counter and debounced level
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_q     <= 1'b0;
            key_s_q    <= 1'b0;
            tick_cnt_q <= '0;
            db_cnt_q   <= 12'd0;
            key_db_q   <= 1'b0;
        end else begin
            sync_q     <= key_in;
            key_s_q    <= sync_q;
            tick_cnt_q <= tick_cnt_d;
            db_cnt_q   <= db_cnt_d;
            key_db_q   <= key_db_d;
        end
    end

    // Press/gap classifier; key_db edges take priority over a coincident tick
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            key_db_prev_q <= 1'b0;
            state_q       <= ST_IDLE;
            press_cnt_q   <= 12'd0;
            gap_cnt_q     <= 12'd0;
            letter_done_q <= 1'b0;
            tap_q         <= 2'd0;
            tap_valid_q   <= 1'b0;
            letter_end_q  <= 1'b0;
            word_end_q    <= 1'b0;
        end else begin
            key_db_prev_q <= key_db_q;
            tap_valid_q   <= 1'b0;
            letter_end_q  <= 1'b0;
            word_end_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_q     <= ST_PRESS;
                        press_cnt_q <= 12'd0;
                    end
                end
                ST_PRESS: begin
                    if (fall_s) begin
                        tap_q         <= (press_cnt_q >= DASH_TH) ? 2'd1 : 2'd2;
                        tap_valid_q   <= 1'b1;
                        gap_cnt_q     <= 12'd0;
                        letter_done_q <= 1'b0;
                        state_q       <= ST_GAP;
                    end else if (tick_s) begin
                        press_cnt_q <= press_inc_s;
                    end
                end
                ST_GAP: begin
                    if (rise_s) begin
                        state_q     <= ST_PRESS;
                        press_cnt_q <= 12'd0;
                    end else if (tick_s) begin
                        gap_cnt_q <= gap_inc_s;
                        if ((gap_inc_s == LET_TH) && !letter_done_q) begin
                            letter_end_q  <= 1'b1;
                            tap_q         <= 2'd0;
                            tap_valid_q   <= 1'b1;
                            letter_done_q <= 1'b1;
                        end
                        if (gap_inc_s == WORD_TH) begin
                            word_end_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign key_db     = key_db_q;
    assign tap        = tap_q;
    assign tap_valid  = tap_valid_q;
    assign letter_end = letter_end_q;
    assign word_end   = word_end_q;

endmodule

// File: tb/tb_morse_key_classifier.sv
// Scoreboard bench for morse_key_classifier: expected symbol events are queued
// as key stimulus is driven and compared when the DUT pulses its outputs.
module tb_morse_key_classifier;

    localparam int TICK_DIV      = 4;
    localparam int DEBOUNCE_MS   = 2;
    localparam int DASH_MS       = 10;
    localparam int LETTER_GAP_MS = 20;
    localparam int WORD_GAP_MS   = 40;

    localparam logic [4:0] EV_DOT  = 5'b00110;
    localparam logic [4:0] EV_DASH = 5'b00101;
    localparam logic [4:0] EV_LET  = 5'b01100;
    localparam logic [4:0] EV_WORD = 5'b10000;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       key_in = 1'b0;
    logic       key_db;
    logic [1:0] tap;
    logic       tap_valid, letter_end, word_end;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] sb_q[$];
    int db_rises = 0;

    morse_key_classifier #(
        .TICK_DIV(TICK_DIV), .DEBOUNCE_MS(DEBOUNCE_MS), .DASH_MS(DASH_MS),
        .LETTER_GAP_MS(LETTER_GAP_MS), .WORD_GAP_MS(WORD_GAP_MS)
    ) dut (
        .clk(clk), .rstb(rstb), .key_in(key_in), .key_db(key_db), .tap(tap),
        .tap_valid(tap_valid), .letter_end(letter_end), .word_end(word_end)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int ticks);
        sb_q.push_back((ticks >= DASH_MS) ? EV_DASH : EV_DOT);
        key_in = 1'b1;
        wait_cyc(ticks * TICK_DIV);
        key_in = 1'b0;
    endtask

    task automatic gap(input int ticks);
        if (ticks >= LETTER_GAP_MS) sb_q.push_back(EV_LET);
        if (ticks >= WORD_GAP_MS) sb_q.push_back(EV_WORD);
        wait_cyc(ticks * TICK_DIV);
    endtask

    // Output monitor: pops the scoreboard on every pulse and checks timing/hold
    initial begin
        logic [4:0] ev, exp_ev;
        logic       pulse, prev_pulse, prev_db;
        logic [1:0] last_tap;
        int         cyc, last_tap_cyc, dly;
        prev_pulse = 1'b0; prev_db = 1'b0; last_tap = 2'd0;
        cyc = 0; last_tap_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (key_db && !prev_db) db_rises++;
            prev_db = key_db;
            if (!rstb) begin
                prev_pulse = 1'b0;
                last_tap   = 2'd0;
            end else begin
                ev    = {word_end, letter_end, tap_valid, tap};
                pulse = word_end | letter_end | tap_valid;
                if (prev_pulse)
                    check_eq("pulse_hold", {27'd0, ev}, {30'd0, last_tap});
                if (pulse) begin
                    if (sb_q.size() == 0) begin
                        check_eq("unexpected_event", {27'd0, ev}, 32'd0);
                    end else begin
                        exp_ev = sb_q.pop_front();
                        check_eq("event", {27'd0, ev}, {27'd0, exp_ev});
                    end
                    dly = cyc - last_tap_cyc;
                    if (letter_end)
                        check_eq("letter_delay", {31'd0, (dly >= 77 && dly <= 81)}, 32'd1);
                    if (word_end)
                        check_eq("word_delay", {31'd0, (dly >= 157 && dly <= 161)}, 32'd1);
                    if (tap_valid && tap != 2'd0) last_tap_cyc = cyc;
                    if (tap_valid) last_tap = tap;
                end
                prev_pulse = pulse;
            end
        end
    end

    initial begin
        int rises0;
        // Reset held with the key toggling
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1 key_in = ~key_in;
            if (i % 8 == 7)
                check_eq("reset_hold", {27'd0, key_db, tap, tap_valid, letter_end, word_end}, 32'd0);
        end
        key_in = 1'b0;
        wait_cyc(2);
        rstb = 1'b1;
        wait_cyc(20);

        // Dots at 5 and 9 ticks, short gap between them
        press(5);
        gap(10);
        press(9);
        gap(45);
        // Dash at exactly threshold and above; long saturating press
        press(10);
        gap(45);
        press(12);
        gap(45);
        press(5000);
        gap(45);

        // Idle glitches must never reach key_db
        rises0 = db_rises;
        for (int i = 0; i < 2; i++) begin
            key_in = 1'b1;
            wait_cyc(TICK_DIV);
            key_in = 1'b0;
            wait_cyc(5 * TICK_DIV);
        end
        check_eq("idle_glitch_rises", db_rises - rises0, 32'd0);

        // 12-tick press with a 1-tick low glitch
        rises0 = db_rises;
        sb_q.push_back(EV_DASH);
        key_in = 1'b1;
        wait_cyc(5 * TICK_DIV);
        key_in = 1'b0;
        wait_cyc(TICK_DIV);
        key_in = 1'b1;
        wait_cyc(6 * TICK_DIV);
        key_in = 1'b0;
        gap(45);
        check_eq("press_glitch_rises", db_rises - rises0, 32'd1);

        // Gap interrupted at tick 30: letter_end only
        press(5);
        gap(30);
        press(5);
        gap(45);

        // Reset in the middle of a press, key held across reset release
        key_in = 1'b1;
        for (int i = 0; i < 100 && !key_db; i++) @(posedge clk);
        #1;
        check_eq("pre_reset_key_db", {31'd0, key_db}, 32'd1);
        wait_cyc(8);
        #1 rstb = 1'b0;
        #1 check_eq("async_reset", {27'd0, key_db, tap, tap_valid, letter_end, word_end}, 32'd0);
        wait_cyc(3);
        rstb = 1'b1;
        sb_q.push_back(EV_DOT);
        wait_cyc(8 * TICK_DIV);
        key_in = 1'b0;
        gap(45);

        wait_cyc(40);
        check_eq("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_key_classifier.md
# morse_key_classifier

Converts the raw Morse key input into timed symbol events: debounces the key, measures press and release durations, and emits dot, dash and space symbols plus letter-end and word-end markers. Sits directly upstream of the Morse character renderer. Its `tap` output uses the renderer's encoding: 2'd0 space/nothing, 2'd1 dash, 2'd2 dot. All timing is in millisecond ticks derived from the system clock.

## Interface
- `TICK_DIV`, default 27000: clock cycles per 1 ms tick (≥2).
- `DEBOUNCE_MS`, default 10: ticks the key must be stable before the debounced level changes (≥1).
- `DASH_MS`, default 200: press length in ticks at or above which the press is a dash.
- `LETTER_GAP_MS`, default 600: release length in ticks that ends a letter.
- `WORD_GAP_MS`, default 1400: release length in ticks that ends a word. Must be > `LETTER_GAP_MS`. All `_MS` parameters must be ≤ 4095.
- `clk` input 1: system clock; all logic on its rising edge.
- `rstb` input 1: asynchronous active-low reset.
- `key_in` input 1: raw key, active-high when pressed, asynchronous to `clk`.
- `key_db` output 1: debounced key level.
- `tap` output 2: last symbol; 2'd1 dash, 2'd2 dot, 2'd0 space.
- `tap_valid` output 1: 1-cycle pulse when `tap` is updated.
- `letter_end` output 1: 1-cycle pulse at letter gap.
- `word_end` output 1: 1-cycle pulse at word gap.

## Operation
- **Synchronizer:** `key_in` passes through 2 flops to give `key_s`.
- **Tick:** a counter runs 0..`TICK_DIV`-1 and wraps. `tick` is high for one cycle at `TICK_DIV`-1. The counter runs freely from reset.
- **Debounce:** a 12-bit counter clears whenever `key_s == key_db`. Otherwise it increments on each `tick`. When it reaches `DEBOUNCE_MS`, `key_db` toggles and the counter clears. Glitches shorter than `DEBOUNCE_MS` ticks are never seen downstream.
- **FSM** has 3 states. It acts on `key_db` edges, detected with a registered copy of `key_db`.
  - **IDLE:** on a rising edge of `key_db`, go to PRESS and clear `press_cnt`.
  - **PRESS:** `press_cnt` (12 bits) increments on `tick` and saturates at 4095. On a falling edge of `key_db`:
    - set `tap` to 2'd1 if `press_cnt` ≥ `DASH_MS`, else 2'd2;
    - pulse `tap_valid`;
    - clear `gap_cnt` and the `letter_done` flag;
    - go to GAP.
  - **GAP:** `gap_cnt` (12 bits) increments on `tick` and saturates at 4095.
    - When `gap_cnt` reaches `LETTER_GAP_MS` and `letter_done` = 0: pulse `letter_end`, set `tap` = 2'd0, pulse `tap_valid`, set `letter_done`.
    - When `gap_cnt` reaches `WORD_GAP_MS`: pulse `word_end`, go to IDLE.
    - On a rising edge of `key_db`: go to PRESS and clear `press_cnt`. This applies whether or not `letter_done` is set. Any pending `word_end` is dropped.
- `tap` holds its value between `tap_valid` pulses.
- **Threshold boundaries:**
  - `press_cnt` == `DASH_MS` gives a dash; `DASH_MS`-1 gives a dot.
  - `gap_cnt` == `LETTER_GAP_MS` fires `letter_end` exactly once per gap.
- A `key_db` edge and a `tick` in the same cycle: the edge wins, and the counter is cleared rather than incremented.

## Timing
- **Reset values** (asynchronous, applied immediately while `rstb` = 0): `key_db`=0, `tap`=2'd0, `tap_valid`=0, `letter_end`=0, `word_end`=0, FSM=IDLE, all counters 0, synchronizer flops 0.
- **Reset mid-operation:** any press or gap in progress is discarded. A key held through reset release is debounced afresh and counts as a new press.
- **Latency:** a `key_in` edge reaches `key_db` after 2 sync cycles plus `DEBOUNCE_MS` ticks (±1 tick for phase).
- **Duration accuracy:** the debounce delay applies equally to both edges, so measured durations match actual ±1 tick.
- `tap_valid` is asserted in the cycle after the clock edge at which `key_db` falls. `letter_end` and `word_end` are asserted in the cycle after the qualifying `tick`.
- All outputs are registered.
- `tap_valid`, `letter_end` and `word_end` are never high more than 1 cycle. `letter_end` and `tap_valid` (with `tap`=0) coincide.

## Test plan
All scenarios use `TICK_DIV`=4, `DEBOUNCE_MS`=2, `DASH_MS`=10, `LETTER_GAP_MS`=20, `WORD_GAP_MS`=40.

1. **Reset:** hold `rstb`=0 with `key_in` toggling → all outputs 0. Assert `rstb`=0 asynchronously mid-cycle → outputs 0 before the next clock edge.
2. **Dot:** press `key_in` for 5 ticks (20 cycles) → exactly one `tap_valid` with `tap`=2'd2. After the release edge, a press of 9 ticks → also 2'd2.
3. **Dash:** press for 12 ticks → one `tap_valid` with `tap`=2'd1. A press held for 5000 ticks → 2'd1, no counter wrap.
4. **Bounce:** 1-tick low glitch inside a 12-tick press, plus 1-tick high pulses while idle → single dash only, and `key_db` never shows the glitches.
5. **Gaps:** a dot, then release for 45 ticks →
   - `letter_end` plus `tap_valid` with `tap`=2'd0 about 20 ticks after the release;
   - `word_end` about 40 ticks after the release;
   - FSM returns to IDLE.
   Repeat with a new press at gap tick 30 → `letter_end` only, no `word_end`.
6. **Reset mid-press:** pulse `rstb` low during an 8-tick press → no `tap_valid` on release. With the key still held after reset, the later release yields one new symbol.
